// File: rtl/push_conditioner_if.sv
// Button bundle between the push pins and the conditioner: raw pins in,
// conditioned levels and strobes out.
interface push_conditioner_if #(
    parameter int unsigned N_BTN = 5
);
    logic [N_BTN-1:0] push_raw;
    logic [N_BTN-1:0] push_level;
    logic [N_BTN-1:0] push_press;
    logic [N_BTN-1:0] push_release;
    logic [N_BTN-1:0] push_step;
    logic [N_BTN-1:0] long_press;
    logic             any_step;

    // Side that owns the pins and consumes the strobes.
    modport master (
        output push_raw,
        input  push_level,
        input  push_press,
        input  push_release,
        input  push_step,
        input  long_press,
        input  any_step
    );

    // The conditioner itself.
    modport slave (
        input  push_raw,
        output push_level,
        output push_press,
        output push_release,
        output push_step,
        output long_press,
        output any_step
    );
endinterface

// File: rtl/push_conditioner.sv
// Push-button conditioner: per channel a two-flop synchroniser, a debounce FSM,
// press/release/step strobes, a debounced level, long-press flag and
// hold-to-repeat step pulses. Channels are fully independent.
module push_conditioner #(
    parameter int unsigned N_BTN         = 5,
    parameter logic [15:0] DEBOUNCE      = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY  = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1000000,
    parameter logic [23:0] LONG_CYCLES   = 24'd10000000
) (
    input  logic              clk,
    input  logic              resetn,
    push_conditioner_if.slave btn_io
);

    localparam logic [15:0] DebLast  = DEBOUNCE - 16'd1;
    localparam logic [23:0] RepFirst = REPEAT_DELAY - 24'd1;
    localparam logic [23:0] RepLast  = REPEAT_PERIOD - 24'd1;
    localparam logic [23:0] LongLast = LONG_CYCLES - 24'd1;
    localparam logic [23:0] HoldMax  = '1;
    localparam bit          DebOne   = (DEBOUNCE == 16'd1);

    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StHeld,
        StDebRel
    } state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    logic [N_BTN-1:0] level_vec;
    logic [N_BTN-1:0] press_vec;
    logic [N_BTN-1:0] release_vec;
    logic [N_BTN-1:0] step_vec;
    logic [N_BTN-1:0] long_vec;

    // Two-stage synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_io.push_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        state_e      state_q;
        logic [15:0] deb_cnt_q;
        logic [23:0] hold_cnt_q;
        logic [23:0] rep_cnt_q;
        logic        level_q;
        logic        press_q;
        logic        release_q;
        logic        step_q;
        logic        long_q;
        logic        s2;
        logic        tick;

        assign s2 = sync2_q[g];
        // Hold time advances on every pressed sample while the button is accepted
        // down, including the sample that cancels a release bounce.
        assign tick = s2 && ((state_q == StHeld) || (state_q == StDebRel));

        // Channel FSM with registered strobes; pulses default low every cycle.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q    <= StIdle;
                deb_cnt_q  <= '0;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                step_q     <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                step_q    <= 1'b0;

                // Hold timing: long-press flag and auto-repeat schedule.
                if (tick) begin
                    if (hold_cnt_q != HoldMax) begin
                        hold_cnt_q <= hold_cnt_q + 24'd1;
                    end
                    if (hold_cnt_q == LongLast) begin
                        long_q <= 1'b1;
                    end
                    if (hold_cnt_q == RepFirst) begin
                        step_q    <= 1'b1;
                        rep_cnt_q <= '0;
                    end else if (hold_cnt_q > RepFirst) begin
                        if (rep_cnt_q == RepLast) begin
                            step_q    <= 1'b1;
                            rep_cnt_q <= '0;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 24'd1;
                        end
                    end
                end

                unique case (state_q)
                    StIdle: begin
                        if (s2) begin
                            if (DebOne) begin
                                state_q    <= StHeld;
                                deb_cnt_q  <= '0;
                                level_q    <= 1'b1;
                                press_q    <= 1'b1;
                                step_q     <= 1'b1;
                                hold_cnt_q <= '0;
                                rep_cnt_q  <= '0;
                            end else begin
                                state_q   <= StDebPress;
                                deb_cnt_q <= 16'd1;
                            end
                        end
                    end
                    StDebPress: begin
                        if (!s2) begin
                            state_q   <= StIdle;
                            deb_cnt_q <= '0;
                        end else if (deb_cnt_q == DebLast) begin
                            state_q    <= StHeld;
                            deb_cnt_q  <= '0;
                            level_q    <= 1'b1;
                            press_q    <= 1'b1;
                            step_q     <= 1'b1;
                            hold_cnt_q <= '0;
                            rep_cnt_q  <= '0;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 16'd1;
                        end
                    end
                    StHeld: begin
                        if (!s2) begin
                            if (DebOne) begin
                                state_q    <= StIdle;
                                deb_cnt_q  <= '0;
                                level_q    <= 1'b0;
                                long_q     <= 1'b0;
                                release_q  <= 1'b1;
                                hold_cnt_q <= '0;
                                rep_cnt_q  <= '0;
                            end else begin
                                state_q   <= StDebRel;
                                deb_cnt_q <= 16'd1;
                            end
                        end
                    end
                    StDebRel: begin
                        if (s2) begin
                            // Release bounce: back to held, no new press.
                            state_q   <= StHeld;
                            deb_cnt_q <= '0;
                        end else if (deb_cnt_q == DebLast) begin
                            state_q    <= StIdle;
                            deb_cnt_q  <= '0;
                            level_q    <= 1'b0;
                            long_q     <= 1'b0;
                            release_q  <= 1'b1;
                            hold_cnt_q <= '0;
                            rep_cnt_q  <= '0;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end

        assign level_vec[g]   = level_q;
        assign press_vec[g]   = press_q;
        assign release_vec[g] = release_q;
        assign step_vec[g]    = step_q;
        assign long_vec[g]    = long_q;
    end

    assign btn_io.push_level   = level_vec;
    assign btn_io.push_press   = press_vec;
    assign btn_io.push_release = release_vec;
    assign btn_io.push_step    = step_vec;
    assign btn_io.long_press   = long_vec;
    assign btn_io.any_step     = |step_vec;

endmodule

// File: tb/tb_push_conditioner.sv
// Bench for push_conditioner: two builds (DEBOUNCE=4 and DEBOUNCE=1) share the
// same pins and reset and are compared every cycle against a run-length model.
module tb_push_conditioner;

    localparam int unsigned NB = 5;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int LC = 40;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    push_conditioner_if #(.N_BTN(NB)) bus0 ();
    push_conditioner_if #(.N_BTN(NB)) bus1 ();

    push_conditioner #(
        .N_BTN(NB), .DEBOUNCE(16'd4), .REPEAT_DELAY(24'(RD)),
        .REPEAT_PERIOD(24'(RP)), .LONG_CYCLES(24'(LC))
    ) dut0 (
        .clk(clk), .resetn(resetn), .btn_io(bus0)
    );

    push_conditioner #(
        .N_BTN(NB), .DEBOUNCE(16'd1), .REPEAT_DELAY(24'(RD)),
        .REPEAT_PERIOD(24'(RP)), .LONG_CYCLES(24'(LC))
    ) dut1 (
        .clk(clk), .resetn(resetn), .btn_io(bus1)
    );

    logic [NB-1:0] raw = '0;
    assign bus0.push_raw = raw;
    assign bus1.push_raw = raw;

    int checks = 0;
    int errors = 0;

    // Reference model: sample pipeline plus, per build/channel, the length of the
    // current run of samples disagreeing with the accepted level and the number
    // of pressed samples seen since the press was accepted.
    logic [NB-1:0] m_s1, m_s2;
    logic [NB-1:0] m_lvl [2];
    logic [NB-1:0] m_prs [2];
    logic [NB-1:0] m_rel [2];
    logic [NB-1:0] m_stp [2];
    logic [NB-1:0] m_lng [2];
    int m_run  [2][NB];
    int m_held [2][NB];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = '0; m_prs[k] = '0; m_rel[k] = '0; m_stp[k] = '0; m_lng[k] = '0;
            for (int c = 0; c < NB; c++) begin
                m_run[k][c]  = 0;
                m_held[k][c] = 0;
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int deb = (k == 0) ? 4 : 1;
            m_prs[k] = '0;
            m_rel[k] = '0;
            m_stp[k] = '0;
            for (int c = 0; c < NB; c++) begin
                logic smp = m_s2[c];
                if (m_lvl[k][c] && smp) begin
                    m_held[k][c]++;
                    if (m_held[k][c] == RD ||
                        (m_held[k][c] > RD && (m_held[k][c] - RD) % RP == 0))
                        m_stp[k][c] = 1'b1;
                    if (m_held[k][c] >= LC) m_lng[k][c] = 1'b1;
                end
                if (smp != m_lvl[k][c]) m_run[k][c]++;
                else m_run[k][c] = 0;
                if (m_run[k][c] == deb) begin
                    m_run[k][c] = 0;
                    m_lvl[k][c] = ~m_lvl[k][c];
                    if (m_lvl[k][c]) begin
                        m_prs[k][c]  = 1'b1;
                        m_stp[k][c]  = 1'b1;
                        m_held[k][c] = 0;
                    end else begin
                        m_rel[k][c] = 1'b1;
                        m_lng[k][c] = 1'b0;
                    end
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic compare_all();
        check("d4.level",   32'(bus0.push_level),   32'(m_lvl[0]));
        check("d4.press",   32'(bus0.push_press),   32'(m_prs[0]));
        check("d4.release", 32'(bus0.push_release), 32'(m_rel[0]));
        check("d4.step",    32'(bus0.push_step),    32'(m_stp[0]));
        check("d4.long",    32'(bus0.long_press),   32'(m_lng[0]));
        check("d4.any",     32'(bus0.any_step),     32'(|m_stp[0]));
        check("d1.level",   32'(bus1.push_level),   32'(m_lvl[1]));
        check("d1.press",   32'(bus1.push_press),   32'(m_prs[1]));
        check("d1.release", 32'(bus1.push_release), 32'(m_rel[1]));
        check("d1.step",    32'(bus1.push_step),    32'(m_stp[1]));
        check("d1.long",    32'(bus1.long_press),   32'(m_lng[1]));
        check("d1.any",     32'(bus1.any_step),     32'(|m_stp[1]));
    endtask

    // One clock: drive pins, advance the model on the edge, check on the falling edge.
    task automatic tick(input logic [NB-1:0] r);
        raw = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input logic [NB-1:0] r);
        raw = r;
        #3 resetn = 1'b0;
        #1;
        model_reset();
        check("rst.level", 32'(bus0.push_level), 32'd0);
        check("rst.step",  32'(bus0.push_step),  32'd0);
        check("rst.long",  32'(bus0.long_press), 32'd0);
        compare_all();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        resetn = 1'b1;
    endtask

    int n, n1, cnt_a, cnt_b, p_idx, long_off;
    bit seen;
    int steps_q[$];
    int exp_steps[6] = '{0, 20, 28, 36, 44, 52};
    logic prev_long;
    logic [NB-1:0] r;
    int pct[NB];

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        resetn = 1'b1;

        // 1: clean press of raw[0], 10 cycles, clean release
        n = 0; n1 = 0;
        for (int i = 0; i < 20; i++) begin
            tick(5'b00001);
            if (n1 == 0 && bus1.push_press[0]) n1 = i + 1;
            if (bus0.push_level[0]) begin n = i + 1; break; end
        end
        check("s1.press_lat", 32'(n), 32'd6);
        check("s1.press", 32'(bus0.push_press[0]), 32'd1);
        check("s1.step", 32'(bus0.push_step[0]), 32'd1);
        check("s6.d1_press_lat", 32'(n1), 32'd3);
        cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            tick(5'b00001);
            if (bus0.push_step[0]) cnt_a++;
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(5'b00000);
            if (bus0.push_step[0]) cnt_a++;
            if (bus0.push_release[0]) begin n = i + 1; break; end
        end
        check("s1.release_lat", 32'(n), 32'd6);
        check("s1.no_repeat", 32'(cnt_a), 32'd0);
        check("s1.level_low", 32'(bus0.push_level[0]), 32'd0);
        for (int i = 0; i < 4; i++) tick(5'b00000);

        // 2: short bounces on raw[2], then a 2-cycle release glitch
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            tick((i < 3 || (i >= 4 && i < 7)) ? 5'b00100 : 5'b00000);
            seen |= bus0.push_level[2] | bus0.push_press[2] | bus0.push_step[2]
                  | bus0.push_release[2];
        end
        check("s2.bounce_quiet", 32'(seen), 32'd0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 30; i++) begin
            tick((i == 12 || i == 13) ? 5'b00000 : 5'b00100);
            if (bus0.push_press[2]) cnt_a++;
            if (bus0.push_release[2]) cnt_b++;
        end
        check("s2.one_press", 32'(cnt_a), 32'd1);
        check("s2.no_release", 32'(cnt_b), 32'd0);
        check("s2.level_held", 32'(bus0.push_level[2]), 32'd1);
        for (int i = 0; i < 10; i++) tick(5'b00000);

        // 3: hold raw[1] for 60 cycles
        p_idx = -1; long_off = -1; prev_long = 1'b0; seen = 0;
        steps_q.delete();
        for (int i = 0; i < 72; i++) begin
            tick((i < 60) ? 5'b00010 : 5'b00000);
            if (bus0.push_press[1]) p_idx = i;
            if (bus0.push_step[1] && p_idx >= 0) steps_q.push_back(i - p_idx);
            if (bus0.long_press[1] && !prev_long && p_idx >= 0) long_off = i - p_idx;
            if (bus0.push_release[1]) begin
                seen = 1;
                check("s3.long_falls", 32'(bus0.long_press[1]), 32'd0);
                check("s3.long_before_rel", 32'(prev_long), 32'd1);
            end
            prev_long = bus0.long_press[1];
        end
        check("s3.release_seen", 32'(seen), 32'd1);
        check("s3.step_count", 32'(steps_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < steps_q.size(); i++)
            check("s3.step_offset", 32'(steps_q[i]), 32'(exp_steps[i]));
        check("s3.long_offset", 32'(long_off), 32'(LC));

        // 4: raw[0] and raw[4] together, raw[4] dropped shortly after the press
        cnt_a = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(5'b10001);
            if (bus0.any_step) cnt_a++;
            if (bus0.push_press[0] || bus0.push_press[4]) begin
                seen = 1;
                check("s4.press0", 32'(bus0.push_press[0]), 32'd1);
                check("s4.press4", 32'(bus0.push_press[4]), 32'd1);
                break;
            end
        end
        check("s4.press_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 22; i++) begin
            tick((i < 2) ? 5'b10001 : ((i < 10) ? 5'b00001 : 5'b00000));
            if (bus0.any_step) cnt_a++;
        end
        check("s4.any_step_once", 32'(cnt_a), 32'd1);

        // 5: reset while raw[3] held past the first repeat
        for (int i = 0; i < 20; i++) begin
            tick(5'b01000);
            if (bus0.push_press[3]) break;
        end
        for (int i = 0; i < 25; i++) tick(5'b01000);
        do_reset(5'b01000);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(5'b01000);
            if (bus0.push_press[3]) begin n = i + 1; break; end
        end
        check("s5.press_lat", 32'(n), 32'd6);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(5'b01000);
            if (bus0.push_step[3]) begin n = i + 1; break; end
        end
        check("s5.first_repeat", 32'(n), 32'(RD));
        for (int i = 0; i < 10; i++) tick(5'b00000);

        // Random pins with varying toggle rates and occasional resets
        r = '0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (cyc % 150 == 0) begin
                for (int c = 0; c < NB; c++) begin
                    case ($urandom_range(0, 2))
                        0: pct[c] = 2;
                        1: pct[c] = 10;
                        default: pct[c] = 40;
                    endcase
                end
            end
            for (int c = 0; c < NB; c++)
                if ($urandom_range(0, 99) < pct[c]) r[c] = ~r[c];
            if ($urandom_range(0, 399) == 0) do_reset(r);
            tick(r);
        end
        for (int i = 0; i < 12; i++) tick(5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
